// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes byte-addressed requests into word accesses,
// splitting word-crossing accesses into two memory cycles.
module load_store_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [63:0] rd_buf;

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
  endfunction

  function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off == 2'd3;
      2'b10:   return off != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  // Byte strobes across the two words touched: [3:0] first word, [7:4] second.
  function automatic logic [7:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return {4'b0000, m} << off;
  endfunction

  function automatic logic [63:0] lane_data(input logic [31:0] d, input logic [1:0] off);
    return {32'b0, d} << {off, 3'b000};
  endfunction

  function automatic logic [31:0] extract(input logic [63:0] b, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [63:0] r;
    r = b >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{r[7]}}, r[7:0]};
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b010:  return r[31:0];
      3'b100:  return {24'b0, r[7:0]};
      3'b101:  return {16'b0, r[15:0]};
      default: return 32'b0;
    endcase
  endfunction

  logic        acc0_split;
  logic [7:0]  r_be8;
  logic [63:0] r_wide;
  logic [7:0]  in_be8;
  logic [63:0] in_wide;

  assign acc0_split = is_split(r_funct3, r_addr[1:0]);
  assign r_be8      = lane_be(r_funct3, r_addr[1:0]);
  assign r_wide     = lane_data(r_wdata, r_addr[1:0]);
  assign in_be8     = lane_be(req_funct3, req_addr[1:0]);
  assign in_wide    = lane_data(req_wdata, req_addr[1:0]);

  // NOTE: all outputs are registers; the async reset clears mem_be the moment
  // srst falls, so a pending second half of a split store can never be issued.
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'b0;
      rsp_err   <= 1'b0;
      mem_addr  <= 30'b0;
      mem_be    <= 4'b0;
      mem_wdata <= 32'b0;
      r_we      <= 1'b0;
      r_funct3  <= 3'b0;
      r_addr    <= 32'b0;
      r_wdata   <= 32'b0;
      rd_buf    <= 64'b0;
    end else begin
      mem_be    <= 4'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'b0;
      rsp_err   <= 1'b0;
      req_ready <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            req_ready <= 1'b0;
            if (is_legal(req_we, req_funct3) &&
                (ALLOW_MISALIGNED || !is_split(req_funct3, req_addr[1:0]))) begin
              state     <= ACC0;
              mem_addr  <= req_addr[31:2];
              mem_be    <= req_we ? in_be8[3:0] : 4'b0;
              mem_wdata <= in_wide[31:0];
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        ACC0: begin
          if (!r_we) rd_buf[31:0] <= mem_rdata;
          if (acc0_split) begin
            state     <= ACC1;
            mem_addr  <= r_addr[31:2] + 30'd1;
            mem_be    <= r_we ? r_be8[7:4] : 4'b0;
            mem_wdata <= r_wide[63:32];
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= r_we ? 32'b0 :
                         extract({rd_buf[63:32], mem_rdata}, r_funct3, r_addr[1:0]);
          end
        end
        ACC1: begin
          if (!r_we) rd_buf[63:32] <= mem_rdata;
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= r_we ? 32'b0 :
                       extract({mem_rdata, rd_buf[31:0]}, r_funct3, r_addr[1:0]);
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit, with a small word memory
// model and a second instance built with misaligned accesses disabled.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        srst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;

  logic        s_req_ready, s_rsp_valid, s_rsp_err;
  logic [31:0] s_rsp_rdata, s_mem_wdata;
  logic [29:0] s_mem_addr;
  logic [3:0]  s_mem_be;

  logic [31:0] mem [0:255];
  logic        be_seen, s_be_seen;
  int          rsp_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .srst(srst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .srst(srst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata),
    .rsp_err(s_rsp_err), .mem_addr(s_mem_addr), .mem_be(s_mem_be),
    .mem_wdata(s_mem_wdata), .mem_rdata(32'h0)
  );

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_be[i]) mem[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  always @(mem_be)   if (mem_be != 4'b0)   be_seen = 1'b1;
  always @(s_mem_be) if (s_mem_be != 4'b0) s_be_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a request, wait (bounded) for req_ready, and return one step after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) check("ready_timeout", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'h0);
    check({tag, "_addr"}, {2'b0, mem_addr}, {2'b0, addr[31:2]});
    tick();
    check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, "_rdata"}, rsp_rdata, exp);
    tick();
  endtask

  initial begin
    int cnt0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rsp_cnt    = 0;
    be_seen    = 1'b0;
    s_be_seen  = 1'b0;
    srst       = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h100;
    req_wdata  = 32'h0;

    // Reset held with a request pending.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", {31'b0, req_ready}, 32'd0);
      check("rst_be", {28'b0, mem_be}, 32'd0);
      check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    end
    srst = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rel_ready", {31'b0, req_ready}, 32'd1);
    check("rel_no_access", {31'b0, be_seen}, 32'd0);
    check("rel_valid", {31'b0, rsp_valid}, 32'd0);

    // Aligned LW with cycle-exact timing.
    mem[8'h40] = 32'hDEADBEEF;
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    check("lw_c1_addr", {2'b0, mem_addr}, 32'h40);
    check("lw_c1_be", {28'b0, mem_be}, 32'd0);
    check("lw_c1_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    check("lw_c2_valid", {31'b0, rsp_valid}, 32'd1);
    check("lw_c2_rdata", rsp_rdata, 32'hDEADBEEF);
    check("lw_c2_err", {31'b0, rsp_err}, 32'd0);
    check("lw_c2_ready", {31'b0, req_ready}, 32'd0);
    tick();
    check("lw_c3_valid", {31'b0, rsp_valid}, 32'd0);
    check("lw_c3_rdata", rsp_rdata, 32'd0);
    check("lw_c3_ready", {31'b0, req_ready}, 32'd1);

    // Byte/halfword extraction and sign handling.
    mem[8'h40] = 32'h80FF1234;
    load_check("lb",  3'b000, 32'h103, 32'hFFFFFF80);
    load_check("lbu", 3'b100, 32'h103, 32'h00000080);
    load_check("lhu", 3'b101, 32'h102, 32'h000080FF);
    load_check("lh",  3'b001, 32'h102, 32'hFFFF80FF);
    load_check("lh0", 3'b001, 32'h100, 32'h00001234);

    // Non-split SB: lane placement.
    be_seen = 1'b0;
    mem[8'h40] = 32'h0;
    issue(1'b1, 3'b000, 32'h101, 32'h12345678);
    check("sb_be", {28'b0, mem_be}, 32'b0010);
    check("sb_wdata", mem_wdata, 32'h34567800);
    tick();
    check("sb_valid", {31'b0, rsp_valid}, 32'd1);
    check("sb_rdata", rsp_rdata, 32'd0);
    check("sb_mem", mem[8'h40], 32'h00007800);
    tick();

    // Split SH across words 0x80/0x81.
    mem[8'h80] = 32'h0;
    mem[8'h81] = 32'h0;
    issue(1'b1, 3'b001, 32'h203, 32'h0000ABCD);
    check("sh_c1_addr", {2'b0, mem_addr}, 32'h80);
    check("sh_c1_be", {28'b0, mem_be}, 32'b1000);
    check("sh_c1_wdata", mem_wdata, 32'hCD000000);
    tick();
    check("sh_c2_addr", {2'b0, mem_addr}, 32'h81);
    check("sh_c2_be", {28'b0, mem_be}, 32'b0001);
    check("sh_c2_wdata", mem_wdata, 32'h000000AB);
    check("sh_c2_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    check("sh_c3_valid", {31'b0, rsp_valid}, 32'd1);
    check("sh_c3_err", {31'b0, rsp_err}, 32'd0);
    check("sh_mem0", mem[8'h80], 32'hCD000000);
    check("sh_mem1", mem[8'h81], 32'h000000AB);
    tick();

    // Split LW at 0x002.
    mem[8'h00] = 32'h33221100;
    mem[8'h01] = 32'h77665544;
    issue(1'b0, 3'b010, 32'h002, 32'h0);
    check("slw_c1_addr", {2'b0, mem_addr}, 32'h0);
    tick();
    check("slw_c2_addr", {2'b0, mem_addr}, 32'h1);
    check("slw_c2_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    check("slw_c3_valid", {31'b0, rsp_valid}, 32'd1);
    check("slw_c3_rdata", rsp_rdata, 32'h55443322);
    tick();

    // Wrap-around of the second word address.
    mem[8'hFF] = 32'hBBAA9988;
    issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    check("wrap_c1_addr", {2'b0, mem_addr}, 32'h3FFFFFFF);
    tick();
    check("wrap_c2_addr", {2'b0, mem_addr}, 32'h0);
    tick();
    check("wrap_rdata", rsp_rdata, 32'h1100BBAA);
    tick();

    // Illegal funct3.
    be_seen = 1'b0;
    issue(1'b0, 3'b011, 32'h100, 32'h0);
    check("ill_valid", {31'b0, rsp_valid}, 32'd1);
    check("ill_err", {31'b0, rsp_err}, 32'd1);
    check("ill_rdata", rsp_rdata, 32'd0);
    tick();
    check("ill_ready", {31'b0, req_ready}, 32'd1);
    check("ill_no_be", {31'b0, be_seen}, 32'd0);

    // Misaligned SW on the strict instance (main instance splits it).
    s_be_seen = 1'b0;
    issue(1'b1, 3'b010, 32'h001, 32'h11223344);
    check("strict_valid", {31'b0, s_rsp_valid}, 32'd1);
    check("strict_err", {31'b0, s_rsp_err}, 32'd1);
    check("strict_rdata", s_rsp_rdata, 32'd0);
    check("main_split_be", {28'b0, mem_be}, 32'b1110);
    tick();
    tick();
    check("main_split_err", {31'b0, rsp_err}, 32'd0);
    check("strict_no_be", {31'b0, s_be_seen}, 32'd0);
    tick();

    // Reset during ACC0 of a split SW.
    issue(1'b1, 3'b010, 32'h1FE, 32'h11223344);
    check("rmid_c1_be", {28'b0, mem_be}, 32'b1100);
    cnt0 = rsp_cnt;
    srst = 1'b0;
    #1;
    check("rmid_be_async", {28'b0, mem_be}, 32'd0);
    be_seen = 1'b0;
    tick();
    tick();
    srst = 1'b1;
    tick();
    check("rmid_ready", {31'b0, req_ready}, 32'd1);
    tick();
    tick();
    check("rmid_no_be", {31'b0, be_seen}, 32'd0);
    check("rmid_no_rsp", rsp_cnt - cnt0, 32'd0);
    check("rmid_valid", {31'b0, rsp_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
